capture_write_scheduler: RTL and testbench

- Sequences writes into the 256x256 display frame buffer (3-bit pixels, dual-clock RAM used single-clock) from an external video source with active-low hsync/vsync.
- Synchronises the source syncs, generates raster write addresses, and shares the RAM write port between live capture and a host "clear frame" request.
- Replaces ad-hoc per-pixel write logic; its outputs drive the RAM write port directly.

---
 rtl/capture_pkg.sv | 27 ++
 rtl/sync_falling_edge.sv | 36 +++
 rtl/capture_write_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_capture_write_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture write scheduler: FSM state
// encoding, default frame geometry and the RAM address packing rule.
package capture_pkg;

  // Default frame buffer geometry: 256x256 pixels of 3 bits ({b, g, r}).
  localparam int DEFAULT_COLS   = 256;
  localparam int DEFAULT_ROWS   = 256;
  localparam int DEFAULT_DATA_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_VSYNC,
    ST_WAIT_HSYNC,
    ST_SKIP,
    ST_LINE
  } state_t;

  // RAM address is the column in the upper bits and the row in the lower
  // row_w bits; the caller truncates the result to its address width.
  function automatic logic [31:0] pack_addr(input logic [15:0] col,
                                            input logic [15:0] row,
                                            input int          row_w);
    return (32'(col) << row_w) | 32'(row);
  endfunction

endpackage

// File: rtl/sync_falling_edge.sv
// Multi-flop synchroniser for an asynchronous active-low sync input, plus a
// history flop so the falling edge can be flagged for exactly one cycle.
module sync_falling_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the raw input through the synchroniser, then keep one sample of
  // history. Reset loads the inactive level so no false edge follows reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // value its predecessor held before this edge; blocking would collapse the
  // chain into a single stage in simulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {STAGES{IDLE_VAL}};
      hist_q <= IDLE_VAL;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign fall = hist_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/capture_write_scheduler.sv
// Drives the frame buffer RAM write port. Live capture writes one pixel per
// cycle along each line of the video source; a host clear fills the whole
// buffer with a constant. Both share the single write port via one FSM.
module capture_write_scheduler
  import capture_pkg::*;
#(
  parameter int COLS        = DEFAULT_COLS,
  parameter int ROWS        = DEFAULT_ROWS,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int HSKIP       = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic [DATA_W-1:0] in_data,
  input  logic              arm,
  input  logic              continuous,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_value,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              clear_done,
  output logic              short_frame
);

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int SKIP_W = (HSKIP > 1) ? $clog2(HSKIP) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t              state, state_d;
  logic [COL_W-1:0]    col, col_d;
  logic [ROW_W-1:0]    row, row_d;
  logic [ADDR_W-1:0]   clr_addr, clr_d;
  logic [SKIP_W-1:0]   skip_cnt, skip_d;
  logic                arm_pending, arm_pending_d;
  logic                frame_done_d, clear_done_d, short_frame_d;
  logic [ADDR_W-1:0]   last_addr;
  logic [DATA_W-1:0]   last_data;
  logic                hsync_fall, vsync_fall;
  logic                skip_last;
  logic [DATA_W-1:0]   data_pipe [SYNC_STAGES+1];
  logic [DATA_W-1:0]   pix;

  sync_falling_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_hsync (
    .clock    (clock),
    .reset    (reset),
    .async_in (in_hsync),
    .fall     (hsync_fall)
  );

  sync_falling_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_vsync (
    .clock    (clock),
    .reset    (reset),
    .async_in (in_vsync),
    .fall     (vsync_fall)
  );

  // Pixel delay line matching the sync path depth (synchroniser + history),
  // so the pixel presented in a LINE cycle lines up with the detected edges.
  // NOTE: the delay line is pure datapath and is deliberately not reset; its
  // contents are only used once a line has started, long after reset.
  always_ff @(posedge clock) begin
    data_pipe[0] <= in_data;
    for (int i = 1; i <= SYNC_STAGES; i++) begin
      data_pipe[i] <= data_pipe[i-1];
    end
  end

  assign pix       = data_pipe[SYNC_STAGES];
  assign skip_last = (32'(skip_cnt) == 32'(HSKIP - 1));
  assign busy      = (state != ST_IDLE);

  // State, counters, pulse outputs and the held write-port values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      col         <= '0;
      row         <= '0;
      clr_addr    <= '0;
      skip_cnt    <= '0;
      arm_pending <= 1'b0;
      frame_done  <= 1'b0;
      clear_done  <= 1'b0;
      short_frame <= 1'b0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      state       <= state_d;
      col         <= col_d;
      row         <= row_d;
      clr_addr    <= clr_d;
      skip_cnt    <= skip_d;
      arm_pending <= arm_pending_d;
      frame_done  <= frame_done_d;
      clear_done  <= clear_done_d;
      short_frame <= short_frame_d;
      last_addr   <= wr_addr;
      last_data   <= wr_data;
    end
  end

  // Next-state, counter updates and the combinational write port. Outside
  // write cycles the port replays the last written address and data.
  // NOTE: every signal assigned below gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state;
    col_d         = col;
    row_d         = row;
    clr_d         = clr_addr;
    skip_d        = skip_cnt;
    arm_pending_d = arm_pending;
    frame_done_d  = 1'b0;
    clear_done_d  = 1'b0;
    short_frame_d = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = last_addr;
    wr_data       = last_data;

    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          // A simultaneous arm is remembered and honoured after the clear.
          state_d       = ST_CLEAR;
          clr_d         = '0;
          arm_pending_d = arm;
        end else if (arm) begin
          state_d = ST_WAIT_VSYNC;
        end
      end

      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_data = clear_value;
        clr_d   = clr_addr + ADDR_W'(1);
        if (arm) begin
          arm_pending_d = 1'b1;
        end
        if (clr_addr == '1) begin
          clear_done_d = 1'b1;
          if (arm_pending || arm) begin
            state_d       = ST_WAIT_VSYNC;
            arm_pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_WAIT_VSYNC: begin
        if (vsync_fall) begin
          row_d   = '0;
          state_d = ST_WAIT_HSYNC;
        end
      end

      ST_WAIT_HSYNC: begin
        if (vsync_fall) begin
          short_frame_d = 1'b1;
          row_d         = '0;
        end else if (hsync_fall) begin
          col_d   = '0;
          skip_d  = '0;
          state_d = (HSKIP == 0) ? ST_LINE : ST_SKIP;
        end
      end

      ST_SKIP: begin
        if (vsync_fall) begin
          short_frame_d = 1'b1;
          row_d         = '0;
          state_d       = ST_WAIT_HSYNC;
        end else if (skip_last) begin
          state_d = ST_LINE;
        end else begin
          skip_d = skip_cnt + SKIP_W'(1);
        end
      end

      ST_LINE: begin
        if (vsync_fall) begin
          // Vsync wins over a coincident hsync: restart the frame.
          short_frame_d = 1'b1;
          row_d         = '0;
          state_d       = ST_WAIT_HSYNC;
        end else if (hsync_fall) begin
          // Early hsync: this edge starts the next line, or ends the frame.
          if (row == ROW_LAST) begin
            frame_done_d = 1'b1;
            state_d      = continuous ? ST_WAIT_VSYNC : ST_IDLE;
          end else begin
            row_d   = row + ROW_W'(1);
            col_d   = '0;
            skip_d  = '0;
            state_d = (HSKIP == 0) ? ST_LINE : ST_SKIP;
          end
        end else begin
          wr_en   = 1'b1;
          wr_addr = ADDR_W'(pack_addr(16'(col), 16'(row), ROW_W));
          wr_data = pix;
          col_d   = col + COL_W'(1);
          if (col == COL_LAST) begin
            if (row == ROW_LAST) begin
              frame_done_d = 1'b1;
              state_d      = continuous ? ST_WAIT_VSYNC : ST_IDLE;
            end else begin
              row_d   = row + ROW_W'(1);
              state_d = ST_WAIT_HSYNC;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_capture_write_scheduler.sv
// Self-checking bench for capture_write_scheduler with a reduced 32x64 frame.
// The reference model lists, per scenario, every write the buffer should
// receive (address = col*ROWS + row) and a monitor compares them in order.
module tb_capture_write_scheduler;

  localparam int COLS        = 32;
  localparam int ROWS        = 64;
  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 3;
  localparam int SYNC_STAGES = 2;
  localparam int HSKIP       = 0;
  localparam int NPIX        = COLS * ROWS;

  logic              clock       = 1'b0;
  logic              reset       = 1'b1;
  logic              in_hsync    = 1'b1;
  logic              in_vsync    = 1'b1;
  logic [DATA_W-1:0] in_data     = '0;
  logic              arm         = 1'b0;
  logic              continuous  = 1'b0;
  logic              clear_req   = 1'b0;
  logic [DATA_W-1:0] clear_value = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              frame_done;
  logic              clear_done;
  logic              short_frame;

  capture_write_scheduler #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SYNC_STAGES(SYNC_STAGES), .HSKIP(HSKIP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .in_data     (in_data),
    .arm         (arm),
    .continuous  (continuous),
    .clear_req   (clear_req),
    .clear_value (clear_value),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .clear_done  (clear_done),
    .short_frame (short_frame)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected write stream and monitor bookkeeping.
  int   exp_addr_q[$];
  int   exp_data_q[$];
  bit   mon_en        = 1'b0;
  int   cyc           = 0;
  int   last_wr_cyc   = -100;
  int   fd_cnt        = 0;
  int   cd_cnt        = 0;
  int   sf_cnt        = 0;
  int   wr_cnt        = 0;
  int   exp_done_gap  = 1;
  bit   exp_cd_busy   = 1'b0;
  bit   busy_chk      = 1'b0;
  int   busy_until_fd = 0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [DATA_W-1:0] hold_data = '0;

  // Compare every write in order against the model; between writes the
  // port must keep its last address/data. Pulses are counted and timed.
  always @(negedge clock) begin
    cyc++;
    if (mon_en) begin
      if (frame_done) begin
        fd_cnt++;
        check("frame_done_gap", cyc - last_wr_cyc, exp_done_gap);
      end
      if (clear_done) begin
        cd_cnt++;
        check("clear_done_gap", cyc - last_wr_cyc, 1);
        check("busy_at_clear_done", busy, exp_cd_busy);
      end
      if (short_frame) sf_cnt++;
      if (busy_chk && fd_cnt < busy_until_fd) check("busy_between_frames", busy, 1);
      if (wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", wr_en, 0);
        end else begin
          check("wr_addr", wr_addr, exp_addr_q.pop_front());
          check("wr_data", wr_data, exp_data_q.pop_front());
        end
        hold_addr = wr_addr;
        hold_data = wr_data;
      end else begin
        check("hold_addr", wr_addr, hold_addr);
        check("hold_data", wr_data, hold_data);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_vsync();
    in_vsync = 1'b0;
    repeat (3) step();
    in_vsync = 1'b1;
    repeat (4) step();
  endtask

  // Clear the buffer with val; with_arm also arms capture in the same cycle.
  task automatic do_clear(input logic [DATA_W-1:0] val, input bit with_arm);
    int cd0, wr0;
    for (int i = 0; i < NPIX; i++) begin
      exp_addr_q.push_back(i);
      exp_data_q.push_back(int'(val));
    end
    cd0 = cd_cnt;
    wr0 = wr_cnt;
    exp_cd_busy = with_arm;
    clear_value = val;
    clear_req   = 1'b1;
    arm         = with_arm;
    step();
    clear_req = 1'b0;
    arm       = 1'b0;
    for (int k = 0; k < NPIX + 20 && cd_cnt == cd0; k++) step();
    repeat (5) step();
    check("clear_done_count", cd_cnt - cd0, 1);
    check("clear_write_count", wr_cnt - wr0, NPIX);
    check("clear_queue_drained", exp_addr_q.size(), 0);
  endtask

  // Send one frame from the source and queue the writes it should produce.
  // cut_row gets cut_len pixels (early hsync); abort_row is cut abort_t
  // cycles after its hsync by a vsync falling edge, which ends the task.
  task automatic send_frame(input bit with_vsync, input int cut_row, input int cut_len,
                            input int abort_row, input int abort_t);
    for (int r = 0; r < ROWS; r++) begin
      int n;
      if (r == abort_row)    n = abort_t - 1;
      else if (r == cut_row) n = cut_len;
      else                   n = COLS;
      for (int c = 0; c < n; c++) begin
        exp_addr_q.push_back(c * ROWS + r);
        exp_data_q.push_back(r % 8);
      end
      if (r == abort_row) break;
    end
    if (with_vsync) pulse_vsync();
    for (int r = 0; r < ROWS; r++) begin
      int period;
      period   = (r == cut_row) ? cut_len + 1 : int'($urandom_range(44, 34));
      in_hsync = 1'b0;
      in_data  = DATA_W'(r);
      repeat (3) step();
      in_hsync = 1'b1;
      if (r == abort_row) begin
        repeat (abort_t - 3) step();
        pulse_vsync();
        return;
      end
      repeat (period - 3) step();
    end
    if (cut_row == ROWS - 1) begin
      in_hsync = 1'b0;
      repeat (3) step();
      in_hsync = 1'b1;
    end
    repeat (COLS + 10) step();
  endtask

  initial begin
    int fd0, sf0, wr0, cut_len, abort_row, abort_t, target;

    // Reset state
    repeat (3) step();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_short_frame", short_frame, 0);
    reset = 1'b0;
    step();
    mon_en = 1'b1;

    // Full clear with value 5
    do_clear(3'b101, 1'b0);
    check("idle_after_clear", busy, 0);

    // Single frame, continuous = 0
    fd0 = fd_cnt; wr0 = wr_cnt;
    pulse_arm();
    send_frame(1'b1, -1, 0, -1, 0);
    check("frame1_done_count", fd_cnt - fd0, 1);
    check("frame1_write_count", wr_cnt - wr0, NPIX);
    check("frame1_drained", exp_addr_q.size(), 0);
    check("frame1_idle", busy, 0);

    // Two continuous frames; the second ends on a short last line
    fd0 = fd_cnt;
    continuous = 1'b1;
    pulse_arm();
    busy_until_fd = fd_cnt + 2;
    busy_chk      = 1'b1;
    exp_done_gap  = 1;
    send_frame(1'b1, -1, 0, -1, 0);
    continuous   = 1'b0;
    exp_done_gap = 2;
    cut_len      = int'($urandom_range(COLS - 2, 4));
    send_frame(1'b1, ROWS - 1, cut_len, -1, 0);
    busy_chk     = 1'b0;
    exp_done_gap = 1;
    check("cont_done_count", fd_cnt - fd0, 2);
    check("cont_drained", exp_addr_q.size(), 0);
    check("cont_idle_after", busy, 0);

    // Line 10 cut short by an early hsync
    fd0 = fd_cnt;
    pulse_arm();
    cut_len = int'($urandom_range(COLS - 2, 4));
    send_frame(1'b1, 10, cut_len, -1, 0);
    check("cut_done_count", fd_cnt - fd0, 1);
    check("cut_drained", exp_addr_q.size(), 0);

    // Vsync abort mid-line, then the restarted frame
    fd0 = fd_cnt; sf0 = sf_cnt;
    pulse_arm();
    abort_row = int'($urandom_range(50, 30));
    abort_t   = int'($urandom_range(COLS - 2, 4));
    send_frame(1'b1, -1, 0, abort_row, abort_t);
    check("abort_short_frame", sf_cnt - sf0, 1);
    check("abort_no_frame_done", fd_cnt - fd0, 0);
    check("abort_drained", exp_addr_q.size(), 0);
    check("abort_still_busy", busy, 1);
    send_frame(1'b0, -1, 0, -1, 0);
    check("restart_done_count", fd_cnt - fd0, 1);
    check("restart_short_frame", sf_cnt - sf0, 1);
    check("restart_drained", exp_addr_q.size(), 0);

    // arm + clear_req together, reset part way through the clear
    target = 'h1234 % NPIX;
    for (int i = 0; i <= target; i++) begin
      exp_addr_q.push_back(i);
      exp_data_q.push_back(3);
    end
    clear_value = 3'd3;
    clear_req   = 1'b1;
    arm         = 1'b1;
    step();
    clear_req = 1'b0;
    arm       = 1'b0;
    for (int k = 0; k < NPIX + 10; k++) begin
      if (wr_en && wr_addr == ADDR_W'(target)) break;
      step();
    end
    check("rst_mid_addr", wr_addr, target);
    check("rst_mid_pending", exp_addr_q.size(), 1);
    mon_en = 1'b0;
    reset  = 1'b1;
    step();
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_wr_addr", wr_addr, 0);
    check("rst_mid_wr_data", wr_data, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pulses", {clear_done, frame_done, short_frame}, 0);
    step();
    check("rst_mid_wr_en_held", wr_en, 0);
    reset = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    hold_addr = '0;
    hold_data = '0;
    step();
    mon_en = 1'b1;

    // Repeat without reset: clear, then straight into capture
    do_clear(DATA_W'($urandom_range(7, 0)), 1'b1);
    fd0 = fd_cnt;
    send_frame(1'b1, -1, 0, -1, 0);
    check("pending_arm_done_count", fd_cnt - fd0, 1);
    check("pending_arm_drained", exp_addr_q.size(), 0);
    check("pending_arm_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
